// File: rtl/apb_requester_if.sv
// APB4 bus bundle between a requester and a completer.
interface apb_requester_if #(
    parameter int ADDR = 32,
    parameter int DATA = 32
);
    localparam int STRB = DATA / 8;

    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [ADDR-1:0] paddr;
    logic [DATA-1:0] pwdata;
    logic [STRB-1:0] pstrobe;
    logic [2:0]      pprot;
    logic            pready;
    logic            pslverr;
    logic [DATA-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr,
        output pwdata, pstrobe, pprot,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr,
        input  pwdata, pstrobe, pprot,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_requester.sv
// APB4 requester: single-beat command port to SETUP/ACCESS transfers,
// with response port and wait-state timeout.
module apb_requester #(
    parameter int ADDR    = 32,
    parameter int DATA    = 32,
    parameter int TIMEOUT = 16,
    localparam int STRB   = DATA / 8
) (
    input  logic            system_clock,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [ADDR-1:0] cmd_addr,
    input  logic [DATA-1:0] cmd_wdata,
    input  logic [STRB-1:0] cmd_strb,
    input  logic [2:0]      cmd_prot,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DATA-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_timeout,
    apb_requester_if.master apb
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t          state_q, state_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [ADDR-1:0] paddr_q, paddr_d;
    logic [DATA-1:0] pwdata_q, pwdata_d;
    logic [STRB-1:0] pstrb_q, pstrb_d;
    logic [2:0]      pprot_q, pprot_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DATA-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rsp_to_q, rsp_to_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            accept;

    assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        wait_d      = wait_q;

        if (rsp_valid_q && rsp_ready)
            rsp_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    pprot_d  = cmd_prot;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                wait_d    = '0;
            end
            ACCESS: begin
                if (apb.pready) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
                    rsp_err_d   = apb.pslverr;
                    rsp_to_d    = 1'b0;
                end else if ((TIMEOUT > 0) && (wait_q == LAST)) begin
                    // pready was checked first, so a late completion wins
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            wait_q      <= wait_d;
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pstrobe = pstrb_q;
    assign apb.pprot   = pprot_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;
endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: latency, wait states, errors,
// timeout, back-pressure and async reset.
module tb_apb_requester;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    int          checks = 0;
    int          errors = 0;

    apb_requester_if #(.ADDR(32), .DATA(32)) apb ();

    apb_requester #(.ADDR(32), .DATA(32), .TIMEOUT(4)) dut (
        .system_clock(clk),
        .reset_n     (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb         (apb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = 3'd2;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_clr"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        cmd_strb    = '0;
        cmd_prot    = '0;
        rsp_ready   = 1'b0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = '0;
        #1;
        chk("rst_psel", {31'd0, apb.psel}, 32'd0);
        chk("rst_pen", {31'd0, apb.penable}, 32'd0);
        chk("rst_paddr", apb.paddr, 32'd0);
        chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
        chk("rst_cmdrdy", {31'd0, cmd_ready}, 32'd1);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: zero-wait write
        apb.pready = 1'b1;
        cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        cyc();
        cmd_valid = 1'b0;
        chk("t1_psel", {31'd0, apb.psel}, 32'd1);
        chk("t1_pen0", {31'd0, apb.penable}, 32'd0);
        chk("t1_paddr", apb.paddr, 32'h10);
        chk("t1_pwrite", {31'd0, apb.pwrite}, 32'd1);
        chk("t1_pwdata", apb.pwdata, 32'hDEADBEEF);
        chk("t1_pstrb", {28'd0, apb.pstrobe}, 32'hF);
        chk("t1_pprot", {29'd0, apb.pprot}, 32'd2);
        chk("t1_cmdrdy", {31'd0, cmd_ready}, 32'd0);
        cyc();
        chk("t1_pen1", {31'd0, apb.penable}, 32'd1);
        chk("t1_rspv0", {31'd0, rsp_valid}, 32'd0);
        cyc();
        chk("t1_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("t1_psel_dn", {31'd0, apb.psel}, 32'd0);
        chk("t1_pen_dn", {31'd0, apb.penable}, 32'd0);
        chk("t1_err", {31'd0, rsp_err}, 32'd0);
        chk("t1_rdata", rsp_rdata, 32'd0);
        chk("t1_rdy_hold", {31'd0, cmd_ready}, 32'd0);
        handshake("t1");

        // 2: read with three wait states
        apb.pready = 1'b0;
        apb.prdata = 32'h12345678;
        cmd(1'b0, 32'h20, 32'hFFFF0000, 4'hF);
        cyc();
        cmd_valid = 1'b0;
        chk("t2_pstrb", {28'd0, apb.pstrobe}, 32'd0);
        chk("t2_pwrite", {31'd0, apb.pwrite}, 32'd0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2_wait_pen", {31'd0, apb.penable}, 32'd1);
            chk("t2_wait_addr", apb.paddr, 32'h20);
            chk("t2_wait_rspv", {31'd0, rsp_valid}, 32'd0);
        end
        apb.pready = 1'b1;
        cyc();
        chk("t2_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("t2_rdata", rsp_rdata, 32'h12345678);
        chk("t2_err", {31'd0, rsp_err}, 32'd0);
        handshake("t2");

        // 3: write with pslverr
        apb.pslverr = 1'b1;
        cmd(1'b1, 32'h30, 32'hA5A5A5A5, 4'h3);
        cyc();
        cmd_valid = 1'b0;
        cyc();
        cyc();
        apb.pslverr = 1'b0;
        chk("t3_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("t3_err", {31'd0, rsp_err}, 32'd1);
        chk("t3_to", {31'd0, rsp_timeout}, 32'd0);
        chk("t3_rdata", rsp_rdata, 32'd0);
        handshake("t3");

        // 4a: timeout after four stalled ACCESS edges
        apb.pready = 1'b0;
        apb.prdata = 32'h0BADF00D;
        cmd(1'b0, 32'h40, 32'd0, 4'h0);
        cyc();
        cmd_valid = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_stall_rspv", {31'd0, rsp_valid}, 32'd0);
            chk("t4_stall_psel", {31'd0, apb.psel}, 32'd1);
        end
        cyc();
        chk("t4_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("t4_err", {31'd0, rsp_err}, 32'd1);
        chk("t4_to", {31'd0, rsp_timeout}, 32'd1);
        chk("t4_rdata", rsp_rdata, 32'd0);
        chk("t4_psel", {31'd0, apb.psel}, 32'd0);
        handshake("t4");

        // 4b: pready on the fourth edge completes normally
        cmd(1'b0, 32'h44, 32'd0, 4'h0);
        cyc();
        cmd_valid = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) cyc();
        apb.pready = 1'b1;
        apb.prdata = 32'hCAFEF00D;
        cyc();
        chk("t4b_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("t4b_err", {31'd0, rsp_err}, 32'd0);
        chk("t4b_to", {31'd0, rsp_timeout}, 32'd0);
        chk("t4b_rdata", rsp_rdata, 32'hCAFEF00D);
        handshake("t4b");

        // 5: back-to-back commands with response back-pressure
        cmd(1'b1, 32'h50, 32'h11111111, 4'hF);
        cyc();
        cyc();
        cyc();
        chk("t5_rspv", {31'd0, rsp_valid}, 32'd1);
        cmd_addr = 32'h54;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t5_bp_rdy", {31'd0, cmd_ready}, 32'd0);
            chk("t5_bp_psel", {31'd0, apb.psel}, 32'd0);
            chk("t5_bp_rspv", {31'd0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        cyc();
        chk("t5_gap_psel", {31'd0, apb.psel}, 32'd0);
        chk("t5_gap_rdy", {31'd0, cmd_ready}, 32'd1);
        cyc();
        cmd_valid = 1'b0;
        chk("t5_b2_psel", {31'd0, apb.psel}, 32'd1);
        chk("t5_b2_addr", apb.paddr, 32'h54);
        cyc();
        cyc();
        chk("t5_b2_rspv", {31'd0, rsp_valid}, 32'd1);
        cyc();
        rsp_ready = 1'b0;
        chk("t5_b2_clr", {31'd0, rsp_valid}, 32'd0);

        // 6: async reset during ACCESS
        apb.pready = 1'b0;
        cmd(1'b0, 32'h60, 32'd0, 4'h0);
        cyc();
        cmd_valid = 1'b0;
        cyc();
        cyc();
        chk("t6_pen_pre", {31'd0, apb.penable}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_psel", {31'd0, apb.psel}, 32'd0);
        chk("t6_pen", {31'd0, apb.penable}, 32'd0);
        chk("t6_rspv", {31'd0, rsp_valid}, 32'd0);
        cyc();
        rst_n = 1'b1;
        chk("t6_rdy", {31'd0, cmd_ready}, 32'd1);
        cyc();
        chk("t6_idle_psel", {31'd0, apb.psel}, 32'd0);
        chk("t6_idle_rspv", {31'd0, rsp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
